lsu_bus_if: RTL and testbench
=============================

Name: lsu_bus_if

Overview:
- Load/store unit sitting directly downstream of the CPU datapath's memory-access point.
- Consumes the ALU-computed effective address, the rt store data and the decoded load/store attributes.
- Drives a variable-latency word-wide data bus with byte enables and returns sign/zero-extended load data to the register-file write mux.
- Stalls the core while an access is outstanding; flags misaligned or illegal accesses and bus timeouts.

Parameters:
- TIMEOUT, 16, cycles to wait for bus_ack in REQ before aborting; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core requests a memory access this cycle; held with all req_* stable while stall=1
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 sign-extend (lb/lh), 0 zero-extend (lbu/lhu)
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data (rt), right-justified
- stall  out  1  freeze PC/pipeline; combinational: req_valid & (state != DONE)
- load_data  out  32  extended load result; valid while load_valid=1
- load_valid  out  1  one-cycle pulse in DONE for a successful load
- misalign  out  1  one-cycle pulse in DONE: misaligned address or req_size=11
- bus_err  out  1  one-cycle pulse in DONE: timeout abort
- bus_req  out  1  registered; access in progress
- bus_we  out  1  registered; write strobe qualifier
- bus_be  out  4  registered byte enables; lane i = bits 8i+7:8i (little-endian lanes)
- bus_addr  out  32  registered; {req_addr[31:2], 2'b00}
- bus_wdata  out  32  registered; store data replicated onto the addressed lanes
- bus_ack  in  1  bus completes the access this cycle; bus_rdata valid when bus_ack=1 for reads
- bus_rdata  in  32  read data

Behaviour:
- States: IDLE, REQ, DONE.
- Reset: state=IDLE; every output 0; timeout counter 0. A reset in REQ drops bus_req on the reset edge and discards the access; no DONE pulse is produced.
- Legality:
  - byte: always legal.
  - half: legal iff addr[0]=0.
  - word: legal iff addr[1:0]=00.
  - size 11: illegal.
- IDLE:
  - req_valid & legal: latch the request, drive bus_req=1, bus_we=req_wen, bus_be and bus_wdata, go to REQ.
  - req_valid & illegal: go to DONE with misalign set; no bus access.
- Byte enables:
  - byte: 0001 << addr[1:0]
  - half: 0011 << addr[1:0]
  - word: 1111
  - Loads drive the same be pattern.
- Write data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- REQ:
  - Hold all bus outputs stable; count cycles from 0.
  - bus_ack=1: deassert bus_req/bus_we/bus_be. For a load, select the lane(s) by the latched addr[1:0] and extend per size/signed into load_data. Go to DONE.
  - TIMEOUT!=0, no ack and count==TIMEOUT-1: abort, bus outputs to 0, load_data=0, set bus_err, go to DONE.
  - ack on the same cycle as the timeout: the ack wins.
- DONE (exactly one cycle):
  - stall=0; load_valid=1 only for a successful load; misalign or bus_err as latched.
  - Next state IDLE unconditionally; flags and load_valid clear.
  - load_data holds its value until the next load completes.
- Latency: a legal access takes min 3 cycles (IDLE, REQ with same-cycle ack, DONE), i.e. 2 stall cycles. An illegal access takes 2 cycles (1 stall cycle).
- A stall=0 cycle with req_valid=0 leaves the unit idle; bus_ack received outside REQ is ignored.

Test Plan:
- Word store: addr=0x0000_0104, wdata=0xDEAD_BEEF, ack on 2nd REQ cycle -> bus_addr=0x104, be=1111, bus_wdata=0xDEADBEEF, we=1; stall high for 3 cycles, no load_valid.
- Signed byte load: addr=0x103, bus_rdata=0x80xx_xxxx -> be=1000, load_data=0xFFFF_FF80, load_valid pulses 1 cycle.
- Unsigned byte load: same addr and rdata -> load_data=0x0000_0080.
- Signed half load: addr=0x102, rdata=0x9234_5678 -> be=1100, load_data=0xFFFF_9234.
- Store half: addr=0x102, wdata=0x0000_ABCD -> be=1100, bus_wdata=0xABCD_ABCD.
- Misaligned half load at addr=0x101 -> misalign pulse, bus_req never asserts, 1 stall cycle.
- Misaligned word store at addr=0x102 -> misalign pulse, bus_req never asserts, 1 stall cycle.
- Timeout: TIMEOUT=4, no ack -> bus_req high exactly 4 cycles, then bus_err pulse, load_data=0.
- Ack arriving in the 4th REQ cycle -> normal completion, no bus_err.
- rst asserted in the 2nd REQ cycle -> next cycle all outputs 0, state IDLE.
- A late bus_ack after the reset has no effect.

Source files
------------

// File: rtl/lsu_bus_if.sv
// ---------------------------------------------------------------------------
// lsu_bus_if -- load/store unit between the CPU memory-access point and a
// variable-latency, word-wide data bus.
//
// The unit takes the effective address, the store data and the decoded
// load/store attributes from the core. It drives one bus access with byte
// enables and returns sign- or zero-extended load data. The core is stalled
// while an access is outstanding. Misaligned or illegal sizes are flagged
// without touching the bus. An access with no bus_ack for TIMEOUT cycles is
// aborted.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   req_*           core request (valid, wen, size, signed, addr, wdata);
//                   held stable while stall=1
//   stall           combinational pipeline freeze: req_valid & (state != DONE)
//   load_data       extended load result; holds until the next load completes
//   load_valid      one-cycle pulse in DONE for a successful load
//   misalign        one-cycle pulse in DONE for a misaligned address or size 11
//   bus_err         one-cycle pulse in DONE for a timeout abort
//   bus_req/we/be/addr/wdata  registered bus request signals
//   bus_ack, bus_rdata        bus completion and read data
// ---------------------------------------------------------------------------
module lsu_bus_if #(
  parameter int TIMEOUT = 16  // REQ cycles to wait for bus_ack; 0 disables
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  addr_lo_q, addr_lo_d;  // latched addr[1:0] for load lane select
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic        legal;
  logic        timeout_hit;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] rd_shifted;
  logic [31:0] load_ext;

  // Request decode: legality, byte enables and lane-replicated store data.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    legal      = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = req_wdata;
    unique case (req_size)
      2'b00: begin
        legal      = 1'b1;
        be_calc    = 4'b0001 << req_addr[1:0];
        wdata_calc = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        legal      = ~req_addr[0];
        be_calc    = 4'b0011 << req_addr[1:0];
        wdata_calc = {2{req_wdata[15:0]}};
      end
      2'b10:   legal = (req_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Load lane select and extension, from the latched request attributes.
  always_comb begin
    rd_shifted = bus_rdata >> {addr_lo_q, 3'b000};
    unique case (size_q)
      2'b00:   load_ext = {{24{signed_q & rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   load_ext = {{16{signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_ext = bus_rdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // State register (all registered state of the unit).
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_lo_q    <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_be_q     <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_lo_q    <= addr_lo_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_be_q     <= bus_be_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // Next-state logic. An ack on the timeout cycle completes normally.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = legal ? REQ : DONE;
      REQ:     if (bus_ack || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values. Flags default to 0 so they pulse for
  // exactly the DONE cycle.
  always_comb begin
    cnt_d        = cnt_q;
    addr_lo_d    = addr_lo_q;
    size_d       = size_q;
    signed_d     = signed_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_be_d     = bus_be_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && legal) begin
          cnt_d       = '0;
          addr_lo_d   = req_addr[1:0];
          size_d      = req_size;
          signed_d    = req_signed;
          bus_req_d   = 1'b1;
          bus_we_d    = req_wen;
          bus_be_d    = be_calc;
          bus_addr_d  = {req_addr[31:2], 2'b00};
          bus_wdata_d = wdata_calc;
        end else if (req_valid) begin
          misalign_d = 1'b1;
        end
      end
      REQ: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          bus_be_d  = '0;
          if (!bus_we_q) begin
            load_data_d  = load_ext;
            load_valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_be_d    = '0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
          load_data_d = '0;
          bus_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign stall      = req_valid && (state_q != DONE);
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign misalign   = misalign_q;
  assign bus_err    = bus_err_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_be     = bus_be_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_if.sv
// ---------------------------------------------------------------------------
// tb_lsu_bus_if -- self-checking bench for lsu_bus_if (TIMEOUT=4).
// Each table entry is one access. Its bus request, stall count and DONE-cycle
// results are known in advance. DONE results go through a scoreboard queue
// that a negedge monitor pops. A hand-written sequence covers reset during
// REQ and a late bus_ack.
// ---------------------------------------------------------------------------
module tb_lsu_bus_if;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  lsu_bus_if #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_wen   (req_wen),
    .req_size  (req_size),
    .req_signed(req_signed),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .load_data (load_data),
    .load_valid(load_valid),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_be    (bus_be),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_cyc;  // REQ cycle (1-based) that gets bus_ack; 0 = never
    logic [3:0]  be;
    logic [31:0] bwdata;
    int          n_req;    // expected REQ cycles (bus_req high)
    logic        lv;
    logic        mis;
    logic        err;
    logic [31:0] ld;
  } vec_t;

  typedef struct {
    logic        lv;
    logic        mis;
    logic        err;
    logic [31:0] ld;
  } done_t;

  int total = 0;
  int bad   = 0;
  done_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wen, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int ack_cyc,
                              input logic [3:0] be, input logic [31:0] bwdata,
                              input int n_req, input logic lv, input logic mis,
                              input logic err, input logic [31:0] ld);
    vec_t v;
    v.wen = wen; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.ack_cyc = ack_cyc; v.be = be; v.bwdata = bwdata;
    v.n_req = n_req; v.lv = lv; v.mis = mis; v.err = err; v.ld = ld;
    return v;
  endfunction

  // DONE-cycle monitor: the only cycle where a request is present and stall=0.
  always @(negedge clk) begin
    if (!rst && req_valid && !stall) begin
      check("sb_pending", sb.size(), 1);
      if (sb.size() > 0) begin
        done_t e;
        e = sb.pop_front();
        check("done_load_valid", load_valid, e.lv);
        check("done_misalign", misalign, e.mis);
        check("done_bus_err", bus_err, e.err);
        check("done_load_data", load_data, e.ld);
      end
    end
  end

  task automatic run_access(input vec_t v, input int idx);
    int    n_stall;
    int    n_req;
    bit    done;
    done_t e;
    string tag;
    tag = $sformatf("v%0d", idx);
    e.lv = v.lv; e.mis = v.mis; e.err = v.err; e.ld = v.ld;
    @(posedge clk); #1;
    req_wen    = v.wen;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_valid  = 1'b1;
    bus_ack    = 1'b0;
    sb.push_back(e);
    n_stall = 0;
    n_req   = 0;
    done    = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
      end else begin
        n_stall++;
        if (bus_req) begin
          n_req++;
          check({tag, "_bus_addr"}, bus_addr, v.addr & ~32'h3);
          check({tag, "_bus_be"}, bus_be, v.be);
          check({tag, "_bus_wdata"}, bus_wdata, v.bwdata);
          check({tag, "_bus_we"}, bus_we, v.wen);
          bus_ack   = (v.ack_cyc != 0) && (n_req == v.ack_cyc);
          bus_rdata = v.rdata;
        end else begin
          bus_ack = 1'b0;
        end
      end
    end
    bus_ack = 1'b0;
    check({tag, "_finished"}, done, 1);
    check({tag, "_stall_cycles"}, n_stall, v.n_req + 1);
    check({tag, "_req_cycles"}, n_req, v.n_req);
    check({tag, "_done_bus_req"}, bus_req, 0);
    check({tag, "_done_bus_be"}, bus_be, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check({tag, "_after_flags"}, {load_valid, misalign, bus_err}, 0);
    check({tag, "_after_stall"}, stall, 0);
  endtask

  vec_t vecs[15];

  initial begin
    int n;
    vecs[0]  = mk(1, 2'b10, 0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 2, 4'b1111, 32'hDEAD_BEEF, 2, 0, 0, 0, 32'h0);
    vecs[1]  = mk(0, 2'b00, 1, 32'h0000_0103, 32'h0, 32'h8012_3456, 1, 4'b1000, 32'h0, 1, 1, 0, 0, 32'hFFFF_FF80);
    vecs[2]  = mk(0, 2'b00, 0, 32'h0000_0103, 32'h0, 32'h8012_3456, 1, 4'b1000, 32'h0, 1, 1, 0, 0, 32'h0000_0080);
    vecs[3]  = mk(0, 2'b01, 1, 32'h0000_0102, 32'h0, 32'h9234_5678, 1, 4'b1100, 32'h0, 1, 1, 0, 0, 32'hFFFF_9234);
    vecs[4]  = mk(1, 2'b01, 0, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 3, 4'b1100, 32'hABCD_ABCD, 3, 0, 0, 0, 32'hFFFF_9234);
    vecs[5]  = mk(0, 2'b01, 1, 32'h0000_0101, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 0, 0, 1, 0, 32'hFFFF_9234);
    vecs[6]  = mk(1, 2'b10, 0, 32'h0000_0102, 32'h1111_2222, 32'h0, 1, 4'b0000, 32'h0, 0, 0, 1, 0, 32'hFFFF_9234);
    vecs[7]  = mk(0, 2'b10, 0, 32'h0000_0200, 32'h0, 32'h5555_5555, 0, 4'b1111, 32'h0, 4, 0, 0, 1, 32'h0);
    vecs[8]  = mk(0, 2'b10, 0, 32'h0000_0204, 32'h0, 32'h1234_5678, 4, 4'b1111, 32'h0, 4, 1, 0, 0, 32'h1234_5678);
    vecs[9]  = mk(0, 2'b11, 0, 32'h0000_0300, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 0, 0, 1, 0, 32'h1234_5678);
    vecs[10] = mk(1, 2'b00, 0, 32'h0000_0001, 32'h0000_00A5, 32'h0, 1, 4'b0010, 32'hA5A5_A5A5, 1, 0, 0, 0, 32'h1234_5678);
    vecs[11] = mk(0, 2'b01, 0, 32'h0000_0002, 32'h0, 32'h8001_FFFF, 2, 4'b1100, 32'h0, 2, 1, 0, 0, 32'h0000_8001);
    vecs[12] = mk(0, 2'b00, 1, 32'h0000_0000, 32'h0, 32'hFFFF_FF7F, 1, 4'b0001, 32'h0, 1, 1, 0, 0, 32'h0000_007F);
    vecs[13] = mk(0, 2'b01, 1, 32'h0000_0000, 32'h0, 32'h1234_F00D, 1, 4'b0011, 32'h0, 1, 1, 0, 0, 32'hFFFF_F00D);
    vecs[14] = mk(1, 2'b10, 0, 32'h0000_0500, 32'hCAFE_F00D, 32'h0, 0, 4'b1111, 32'hCAFE_F00D, 4, 0, 0, 1, 32'h0);

    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_bus", {bus_req, bus_we, bus_be, stall}, 0);
    check("reset_bus_addr", bus_addr, 0);
    check("reset_bus_wdata", bus_wdata, 0);
    check("reset_flags", {load_valid, misalign, bus_err}, 0);
    check("reset_load_data", load_data, 0);
    rst = 1'b0;

    foreach (vecs[i]) run_access(vecs[i], i);

    // Reset in the 2nd REQ cycle of a load, then a late bus_ack.
    @(posedge clk); #1;
    req_wen = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h0000_0400; req_wdata = '0; req_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk);
      if (bus_req) n++;
    end
    check("rst_req_seen", n, 2);
    rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_bus", {bus_req, bus_we, bus_be, stall}, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_flags", {load_valid, misalign, bus_err}, 0);
    check("rst_load_data", load_data, 0);
    rst = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    check("late_ack_flags", {load_valid, misalign, bus_err, bus_req}, 0);
    check("late_ack_load_data", load_data, 0);
    @(negedge clk);
    check("late_ack_idle", {load_valid, bus_req, stall}, 0);

    // Unit must be back in IDLE and serve a normal access.
    run_access(vecs[0], 100);
    run_access(vecs[1], 101);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "global timeout");
  end

endmodule
